// File: rtl/frv_lsu_response_if.sv
// Data-memory response channel between the memory system and the LSU response stage.
// The memory side drives the response; the LSU side returns the accept strobe.
interface frv_lsu_response_if;
    logic        dmem_recv;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        dmem_error;

    modport master (
        output dmem_recv,
        output dmem_rdata,
        output dmem_error,
        input  dmem_ack
    );

    modport slave (
        input  dmem_recv,
        input  dmem_rdata,
        input  dmem_error,
        output dmem_ack
    );
endinterface

// File: rtl/frv_lsu_response.sv
// Stage-4 LSU response unit: tracks granted-but-unanswered data-memory requests,
// pairs responses with the stage-4 load/store, aligns and extends load data, and
// silently drains responses that belong to flushed instructions.
// Optional macro FRV_LSU_BUS_ERROR_EN: when defined, dmem/MMIO errors raise an
// access-fault trap (cause 5 for loads, 7 for stores); otherwise errors are ignored.
module frv_lsu_response #(
    parameter int MAX_OUTSTANDING  = 2,
    parameter int MMIO_RESP_CYCLES = 0
) (
    input  logic                     g_clk,
    input  logic                     g_resetn,
    input  logic                     flush,
    input  logic                     req_issued,
    input  logic                     s4_valid,
    output logic                     s4_busy,
    input  logic                     s4_load,
    input  logic                     s4_store,
    input  logic                     s4_byte,
    input  logic                     s4_half,
    input  logic                     s4_signed,
    input  logic                     s4_mmio,
    input  logic [1:0]               s4_addr_lo,
    input  logic                     s4_trap_in,
    frv_lsu_response_if.slave        bus,
    input  logic [31:0]              mmio_rdata,
    input  logic                     mmio_error,
    output logic                     o_valid,
    output logic [31:0]              o_wdata,
    output logic                     o_trap,
    output logic [5:0]               o_cause,
    input  logic                     i_busy
);

    localparam int            CW        = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_OUTSTANDING);
    localparam int            MW        = (MMIO_RESP_CYCLES > 1) ? $clog2(MMIO_RESP_CYCLES) : 1;
    localparam logic [MW-1:0] MMIO_LAST = MW'((MMIO_RESP_CYCLES > 0) ? MMIO_RESP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        MMIO,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic          buf_valid;
    logic [31:0]   buf_rdata;
    logic          buf_error;
    logic [MW-1:0] mmio_cnt;
    logic [MW-1:0] mmio_cnt_next;
    logic          drop_active;
    logic          accept;
    logic          dec_out;
    logic          take_resp;
    logic          load_result;
    logic [31:0]   src_rdata;
    logic          src_error;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   res_wdata;
    logic [31:0]   wdata_q;

    // Responses are accepted whenever they will be dropped or there is room to hold them.
    assign drop_active  = (drop != '0);
    assign bus.dmem_ack = bus.dmem_recv && (drop_active || !buf_valid);
    assign accept       = bus.dmem_recv && bus.dmem_ack;
    assign dec_out      = accept && (outstanding != '0);
    assign take_resp    = accept && !drop_active;

    // Outstanding and drop counters; a flush turns every live request into one to drain.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_issued) - CW'(dec_out);
            if (flush) begin
                drop <= outstanding - CW'(dec_out);
            end else if (accept && drop_active) begin
                drop <= drop - CW'(1);
            end
        end
    end

    // One-entry buffer for a live response that arrives before stage 4 is waiting for it.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            buf_valid <= 1'b0;
            buf_rdata <= '0;
            buf_error <= 1'b0;
        end else if (flush) begin
            buf_valid <= 1'b0;
        end else if (state == WAIT && buf_valid) begin
            buf_valid <= 1'b0;
        end else if (take_resp && state != WAIT) begin
            buf_valid <= 1'b1;
            buf_rdata <= bus.dmem_rdata;
            buf_error <= bus.dmem_error;
        end
    end

    // Pick the data source for the current instruction and align/extend it.
    always_comb begin
        src_rdata = mmio_rdata;
        src_error = mmio_error;
        if (state == WAIT) begin
            src_rdata = buf_valid ? buf_rdata : bus.dmem_rdata;
            src_error = buf_valid ? buf_error : bus.dmem_error;
        end
        byte_sel  = src_rdata[{s4_addr_lo, 3'b000} +: 8];
        half_sel  = src_rdata[{s4_addr_lo[1], 4'b0000} +: 16];
        res_wdata = '0;
        if (s4_load) begin
            if (s4_byte) begin
                res_wdata = {{24{s4_signed && byte_sel[7]}}, byte_sel};
            end else if (s4_half) begin
                res_wdata = {{16{s4_signed && half_sel[15]}}, half_sel};
            end else begin
                res_wdata = src_rdata;
            end
        end
`ifdef FRV_LSU_BUS_ERROR_EN
        if (src_error && (s4_load || s4_store)) begin
            res_wdata = '0;
        end
`endif
    end

    // Next-state logic; flush overrides everything and abandons the stage-4 instruction.
    always_comb begin
        state_next    = state;
        mmio_cnt_next = mmio_cnt;
        load_result   = 1'b0;
        case (state)
            IDLE: begin
                if (s4_valid) begin
                    if (s4_trap_in || !(s4_load || s4_store)) begin
                        state_next = DONE;
                    end else if (!s4_mmio) begin
                        state_next = WAIT;
                    end else if (MMIO_RESP_CYCLES > 0) begin
                        state_next    = MMIO;
                        mmio_cnt_next = '0;
                    end else begin
                        state_next  = DONE;
                        load_result = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (buf_valid || take_resp) begin
                    state_next  = DONE;
                    load_result = 1'b1;
                end
            end
            MMIO: begin
                if (mmio_cnt == MMIO_LAST) begin
                    state_next  = DONE;
                    load_result = 1'b1;
                end else begin
                    mmio_cnt_next = mmio_cnt + MW'(1);
                end
            end
            DONE: begin
                if (!i_busy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (flush) begin
            state_next  = IDLE;
            load_result = 1'b0;
        end
    end

    // State register and result capture; results read as zero outside DONE.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state    <= IDLE;
            mmio_cnt <= '0;
            wdata_q  <= '0;
        end else begin
            state    <= state_next;
            mmio_cnt <= mmio_cnt_next;
            if (load_result) begin
                wdata_q <= res_wdata;
            end else if (state_next != DONE) begin
                wdata_q <= '0;
            end
        end
    end

`ifdef FRV_LSU_BUS_ERROR_EN
    logic       trap_q;
    logic [5:0] cause_q;

    // Access-fault capture alongside the result; a store fault reports cause 7, a load 5.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            trap_q  <= 1'b0;
            cause_q <= '0;
        end else if (load_result) begin
            trap_q  <= src_error && (s4_load || s4_store);
            cause_q <= (src_error && (s4_load || s4_store)) ? (s4_store ? 6'd7 : 6'd5) : 6'd0;
        end else if (state_next != DONE) begin
            trap_q  <= 1'b0;
            cause_q <= '0;
        end
    end

    assign o_trap  = trap_q;
    assign o_cause = cause_q;
`else
    logic unused_error;
    assign unused_error = src_error;
    assign o_trap       = 1'b0;
    assign o_cause      = 6'd0;
`endif

    assign o_valid = (state == DONE);
    assign o_wdata = wdata_q;
    assign s4_busy = s4_valid && !(state == DONE && !i_busy);

    a_no_overflow: assert property (@(posedge g_clk) disable iff (!g_resetn)
        !(req_issued && (outstanding == MAX_CNT)));

endmodule

// File: tb/tb_frv_lsu_response.sv
// Directed bench for frv_lsu_response: a vector table of single load/store
// transactions plus hand-written sequences for buffering, flush draining and reset.
module tb_frv_lsu_response;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        flush;
    logic        req_issued;
    logic        s4_valid;
    logic        s4_busy;
    logic        s4_load;
    logic        s4_store;
    logic        s4_byte;
    logic        s4_half;
    logic        s4_signed;
    logic        s4_mmio;
    logic [1:0]  s4_addr_lo;
    logic        s4_trap_in;
    logic [31:0] mmio_rdata;
    logic        mmio_error;
    logic        o_valid;
    logic [31:0] o_wdata;
    logic        o_trap;
    logic [5:0]  o_cause;
    logic        i_busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        load;
        logic        store;
        logic        byte_w;
        logic        half_w;
        logic        sgn;
        logic        mmio;
        logic [1:0]  addr;
        logic        trap_in;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[17];

    frv_lsu_response_if bus ();

    frv_lsu_response dut (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .flush      (flush),
        .req_issued (req_issued),
        .s4_valid   (s4_valid),
        .s4_busy    (s4_busy),
        .s4_load    (s4_load),
        .s4_store   (s4_store),
        .s4_byte    (s4_byte),
        .s4_half    (s4_half),
        .s4_signed  (s4_signed),
        .s4_mmio    (s4_mmio),
        .s4_addr_lo (s4_addr_lo),
        .s4_trap_in (s4_trap_in),
        .bus        (bus),
        .mmio_rdata (mmio_rdata),
        .mmio_error (mmio_error),
        .o_valid    (o_valid),
        .o_wdata    (o_wdata),
        .o_trap     (o_trap),
        .o_cause    (o_cause),
        .i_busy     (i_busy)
    );

    // Free-running clock.
    always #5 g_clk = ~g_clk;

    task automatic tick;
        @(posedge g_clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        s4_load    = v.load;
        s4_store   = v.store;
        s4_byte    = v.byte_w;
        s4_half    = v.half_w;
        s4_signed  = v.sgn;
        s4_mmio    = v.mmio;
        s4_addr_lo = v.addr;
        s4_trap_in = v.trap_in;
        mmio_rdata = v.mmio ? v.rdata : 32'h0;
        mmio_error = v.mmio ? v.err : 1'b0;
        s4_valid   = 1'b1;
    endtask

    task automatic clear_stage;
        s4_valid   = 1'b0;
        s4_load    = 1'b0;
        s4_store   = 1'b0;
        s4_byte    = 1'b0;
        s4_half    = 1'b0;
        s4_signed  = 1'b0;
        s4_mmio    = 1'b0;
        s4_addr_lo = 2'd0;
        s4_trap_in = 1'b0;
        mmio_rdata = 32'h0;
        mmio_error = 1'b0;
    endtask

    task automatic run_vector(input vec_t v, input string tag);
        logic        mem;
        logic [31:0] exp_w;
        logic        exp_t;
        logic [5:0]  exp_c;
        mem   = (v.load || v.store) && !v.mmio && !v.trap_in;
        exp_w = v.exp_wdata;
        exp_t = 1'b0;
        exp_c = 6'd0;
`ifdef FRV_LSU_BUS_ERROR_EN
        if (v.err && !v.trap_in && (v.load || v.store)) begin
            exp_w = 32'h0;
            exp_t = 1'b1;
            exp_c = v.store ? 6'd7 : 6'd5;
        end
`endif
        apply_stimulus(v);
        req_issued = mem;
        #1;
        check_output({tag, " busy_start"}, {31'b0, s4_busy}, 32'd1);
        tick;
        req_issued = 1'b0;
        if (mem) begin
            bus.dmem_recv  = 1'b1;
            bus.dmem_rdata = v.rdata;
            bus.dmem_error = v.err;
            #1;
            check_output({tag, " ack"}, {31'b0, bus.dmem_ack}, 32'd1);
            check_output({tag, " valid_early"}, {31'b0, o_valid}, 32'd0);
            tick;
            bus.dmem_recv  = 1'b0;
            bus.dmem_rdata = 32'h0;
            bus.dmem_error = 1'b0;
        end
        check_output({tag, " valid"}, {31'b0, o_valid}, 32'd1);
        check_output({tag, " wdata"}, o_wdata, exp_w);
        check_output({tag, " trap"}, {31'b0, o_trap}, {31'b0, exp_t});
        check_output({tag, " cause"}, {26'b0, o_cause}, {26'b0, exp_c});
        check_output({tag, " busy_done"}, {31'b0, s4_busy}, 32'd0);
        tick;
        clear_stage;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // load, store, byte, half, signed, mmio, addr, trap_in, rdata, err, expected wdata
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 32'h80AABBCC, 1'b0, 32'hFFFFFF80};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 32'h80AABBCC, 1'b0, 32'h00000080};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h80AABBCC, 1'b0, 32'hFFFFFFCC};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 32'h80AABBCC, 1'b0, 32'h000000BB};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h80011234, 1'b0, 32'hFFFF8001};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h80011234, 1'b0, 32'h00008001};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 32'h80011234, 1'b0, 32'h00001234};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h12345678, 1'b0, 32'h00000000};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h12345678, 1'b1, 32'h00000000};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h01234567, 1'b0, 32'h01234567};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 32'h01234567, 1'b0, 32'h00000023};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0000FFFE, 1'b0, 32'hFFFFFFFE};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h00000000, 1'b1, 32'h00000000};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 32'h55555555, 1'b0, 32'h00000000};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h7FFF0000, 1'b0, 32'h00007FFF};

        g_resetn       = 1'b0;
        flush          = 1'b0;
        req_issued     = 1'b0;
        i_busy         = 1'b0;
        bus.dmem_recv  = 1'b0;
        bus.dmem_rdata = 32'h0;
        bus.dmem_error = 1'b0;
        clear_stage;
        repeat (3) tick;

        // Reset values.
        check_output("reset valid", {31'b0, o_valid}, 32'd0);
        check_output("reset wdata", o_wdata, 32'd0);
        check_output("reset trap", {31'b0, o_trap}, 32'd0);
        check_output("reset cause", {26'b0, o_cause}, 32'd0);
        check_output("reset busy", {31'b0, s4_busy}, 32'd0);
        check_output("reset ack", {31'b0, bus.dmem_ack}, 32'd0);
        g_resetn = 1'b1;
        tick;

        for (int i = 0; i < 17; i++) begin
            run_vector(vecs[i], $sformatf("vec%0d", i));
        end

        // Response for the next load arrives while the previous one stalls in DONE.
        apply_stimulus('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0});
        req_issued = 1'b1;
        tick;
        bus.dmem_recv  = 1'b1;
        bus.dmem_rdata = 32'hA5A50F0F;
        #1;
        check_output("buf first ack", {31'b0, bus.dmem_ack}, 32'd1);
        tick;
        req_issued     = 1'b0;
        i_busy         = 1'b1;
        bus.dmem_rdata = 32'h11223344;
        #1;
        check_output("buf second ack", {31'b0, bus.dmem_ack}, 32'd1);
        check_output("buf stall valid", {31'b0, o_valid}, 32'd1);
        check_output("buf stall busy", {31'b0, s4_busy}, 32'd1);
        tick;
        i_busy         = 1'b0;
        bus.dmem_rdata = 32'hDEAD0000;
        #1;
        check_output("buf full ack", {31'b0, bus.dmem_ack}, 32'd0);
        check_output("buf first wdata", o_wdata, 32'hA5A50F0F);
        bus.dmem_recv  = 1'b0;
        bus.dmem_rdata = 32'h0;
        tick;
        apply_stimulus('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0});
        #1;
        check_output("buf idle valid", {31'b0, o_valid}, 32'd0);
        tick;
        check_output("buf wait valid", {31'b0, o_valid}, 32'd0);
        tick;
        check_output("buf second valid", {31'b0, o_valid}, 32'd1);
        check_output("buf second wdata", o_wdata, 32'h00003344);
        tick;
        clear_stage;

        // Two requests in flight, flush, then both responses drain silently.
        apply_stimulus('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0});
        req_issued = 1'b1;
        tick;
        tick;
        req_issued = 1'b0;
        flush      = 1'b1;
        tick;
        flush = 1'b0;
        clear_stage;
        for (int k = 0; k < 2; k++) begin
            bus.dmem_recv  = 1'b1;
            bus.dmem_rdata = 32'hBAD00000 + k;
            #1;
            check_output($sformatf("drain%0d ack", k), {31'b0, bus.dmem_ack}, 32'd1);
            check_output($sformatf("drain%0d valid", k), {31'b0, o_valid}, 32'd0);
            tick;
        end
        bus.dmem_recv  = 1'b0;
        bus.dmem_rdata = 32'h0;
        check_output("drain after valid", {31'b0, o_valid}, 32'd0);
        tick;
        check_output("drain idle valid", {31'b0, o_valid}, 32'd0);
        run_vector('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 32'h00007700, 1'b0, 32'h00000077}, "post_flush");

        // Reset while waiting with one request outstanding.
        apply_stimulus('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0});
        req_issued = 1'b1;
        tick;
        req_issued = 1'b0;
        g_resetn   = 1'b0;
        clear_stage;
        tick;
        check_output("rst_wait valid", {31'b0, o_valid}, 32'd0);
        check_output("rst_wait wdata", o_wdata, 32'd0);
        check_output("rst_wait busy", {31'b0, s4_busy}, 32'd0);
        check_output("rst_wait ack", {31'b0, bus.dmem_ack}, 32'd0);
        g_resetn = 1'b1;
        tick;
        bus.dmem_recv  = 1'b1;
        bus.dmem_rdata = 32'h000000F1;
        #1;
        check_output("rst_stray ack", {31'b0, bus.dmem_ack}, 32'd1);
        tick;
        bus.dmem_rdata = 32'h000000F2;
        #1;
        check_output("rst_stray full ack", {31'b0, bus.dmem_ack}, 32'd0);
        bus.dmem_recv  = 1'b0;
        bus.dmem_rdata = 32'h0;
        apply_stimulus('{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0});
        tick;
        tick;
        check_output("rst_stray valid", {31'b0, o_valid}, 32'd1);
        check_output("rst_stray wdata", o_wdata, 32'hFFFFFFF1);
        tick;
        clear_stage;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frv_lsu_response.md
Name: frv_lsu_response

Overview:
- Sits directly downstream of the memory stage, in stage 4 ahead of register writeback.
- Tracks data-memory requests that have been granted but not yet answered.
- Pairs each response with the stage-4 load or store instruction it belongs to.
- For loads, aligns and sign/zero-extends read data into the writeback value. Raises access-fault traps. Silently drains responses belonging to flushed instructions.

Parameters:
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered requests; the counter is clog2(MAX_OUTSTANDING+1) bits wide.
- MMIO_RESP_CYCLES, 0, fixed MMIO read latency in cycles; 0 means MMIO data is valid in the same cycle stage 4 becomes valid.

Ports:
- g_clk  in  1  global clock
- g_resetn  in  1  synchronous active-low reset
- flush  in  1  discard stage-4 instruction and all younger requests
- req_issued  in  1  pulse: dmem_req && dmem_gnt seen in the memory stage
- s4_valid  in  1  stage-4 instruction valid
- s4_busy  out  1  stage 4 cannot accept/retire yet
- s4_load  in  1  instruction is a load
- s4_store  in  1  instruction is a store
- s4_byte  in  1  byte width
- s4_half  in  1  halfword width
- s4_signed  in  1  sign-extend loaded data
- s4_mmio  in  1  access targeted MMIO (no dmem response expected)
- s4_addr_lo  in  2  address bits [1:0]
- s4_trap_in  in  1  upstream trap already pending
- dmem_recv  in  1  memory response valid
- dmem_ack  out  1  response accepted
- dmem_rdata  in  32  response read data
- dmem_error  in  1  response bus error
- mmio_rdata  in  32  MMIO read data
- mmio_error  in  1  MMIO error
- o_valid  out  1  writeback value/trap ready
- o_wdata  out  32  aligned load result
- o_trap  out  1  access fault raised
- o_cause  out  6  trap cause
- i_busy  in  1  writeback not accepting

Behaviour:
- Reset values: outstanding=0, drop=0, buffer empty, state IDLE, all outputs 0.
- Outstanding counter: +1 on req_issued; -1 on every accepted dmem_recv; both in the same cycle leaves it unchanged. req_issued when outstanding==MAX_OUTSTANDING is illegal and must be asserted against in simulation.
- dmem_ack = dmem_recv && (drop>0 || buffer empty). A response is never lost.
- Flush: drop <= outstanding minus any response accepted this cycle. Clear the buffer. Return to IDLE. While drop>0, every accepted response decrements drop and is discarded.
- One-entry response buffer: captures {rdata,error} when a response arrives and drop==0 but stage 4 is not ready to consume it.
- State machine:
  - IDLE: on s4_valid, go to WAIT if load/store is non-MMIO and not s4_trap_in; otherwise go to MMIO (MMIO_RESP_CYCLES>0) or DONE.
  - WAIT: stay until the buffer is full or a response is accepted with drop==0, then go to DONE.
  - MMIO: count MMIO_RESP_CYCLES, then go to DONE.
  - DONE: o_valid=1; on !i_busy return to IDLE.
- s4_busy = s4_valid && !(state==DONE && !i_busy).
- Latency: a response in the cycle after entering WAIT gives o_valid one cycle later.
- Alignment: byte selects rdata[8*addr_lo+:8]; half selects rdata[16*addr_lo[1]+:16]; word passes through. Extension is sign or zero per s4_signed. Stores give o_wdata=0.
- s4_trap_in: o_valid in one cycle, no response consumed, o_trap=0 (trap carried by writeback).
- Flush takes priority over every other event in the same cycle.

Optional Feature:
- Macro FRV_LSU_BUS_ERROR_EN.
- Defined: dmem_error/mmio_error set o_trap=1 with o_cause=5 (load access fault) or 7 (store access fault), and o_wdata=0.
- Undefined: error inputs are ignored; o_trap is tied to 0 and o_cause to 0.

Test Plan:
- lb, signed, addr_lo=3, rdata=0x80AABBCC, response 1 cycle after s4_valid -> o_wdata=0xFFFFFF80, o_valid 1 cycle later.
- lhu addr_lo=2, rdata=0x8001_1234 -> o_wdata=0x00008001.
- Response arrives while i_busy=1 in DONE of the previous instruction -> buffered; the next load completes without a new dmem_recv.
- Two req_issued, flush, then two dmem_recv -> both acked, drop 2->0, o_valid never asserted.
- Store with dmem_error=1, macro defined -> o_trap=1, o_cause=7; macro undefined -> o_trap=0.
- Reset asserted in WAIT with outstanding=1 -> all state 0; a later dmem_recv with no request is acked into the empty buffer.
